alu_serial_sched: RTL and testbench

ALU_SERIAL_SCHED -- requirements
Module: alu_serial_sched

---
 rtl/alu_serial_sched.sv | 145 ++++++++++++++
 tb/tb_alu_serial_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_sched.sv
// Bit-serial ALU scheduler: arbitrates two requesters onto an
// external 1-bit ALU and assembles the result LSB first.
module alu_serial_sched #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [1:0][WIDTH-1:0] opn_a_i,
  input  logic [1:0][WIDTH-1:0] opn_b_i,
  input  logic [1:0][1:0]       opn_ctl_i,
  output logic [1:0]            gnt_o,
  output logic [WIDTH-1:0]      res_o,
  output logic                  carry_o,
  output logic                  owner_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  alu_a_o,
  output logic                  alu_b_o,
  output logic                  alu_c_o,
  output logic [1:0]            alu_ctr_o,
  input  logic                  alu_d_i,
  input  logic                  alu_e_i
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       ctl_q;
  logic             idx_q;
  logic             last_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             gnt_idx;
  logic             start;
  logic             last_bit;
  logic             is_add;

  assign start    = (state_q == IDLE) && (req_i != 2'b00);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign is_add   = (ctl_q == 2'b00);

  // Round-robin pick: on a tie, the requester that did not own last.
  always_comb begin
    gnt_idx = 1'b0;
    unique case (1'b1)
      (req_i == 2'b11): gnt_idx = ~last_q;
      (req_i == 2'b10): gnt_idx = 1'b1;
      default:          gnt_idx = 1'b0;
    endcase
  end

  // Merge the current ALU bit into the result accumulator.
  always_comb begin
    acc_d        = acc_q;
    acc_d[cnt_q] = alu_d_i;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake / ALU drive outputs.
  always_comb begin
    state_d   = state_q;
    gnt_o     = 2'b00;
    done_o    = 1'b0;
    busy_o    = 1'b0;
    alu_a_o   = 1'b0;
    alu_b_o   = 1'b0;
    alu_c_o   = 1'b0;
    alu_ctr_o = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy_o    = 1'b1;
        alu_a_o   = a_q[cnt_q];
        alu_b_o   = b_q[cnt_q];
        alu_ctr_o = ctl_q;
        alu_c_o   = is_add & carry_q;
        if (cnt_q == '0) gnt_o = idx_q ? 2'b10 : 2'b01;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, bit counter, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= 2'b00;
      idx_q   <= 1'b0;
      last_q  <= 1'b1;
      acc_q   <= '0;
      res_o   <= '0;
      carry_o <= 1'b0;
      owner_o <= 1'b0;
    end else begin
      if (start) begin
        a_q     <= opn_a_i[gnt_idx];
        b_q     <= opn_b_i[gnt_idx];
        ctl_q   <= opn_ctl_i[gnt_idx];
        idx_q   <= gnt_idx;
        last_q  <= gnt_idx;
        cnt_q   <= '0;
        carry_q <= 1'b0;
        acc_q   <= '0;
      end else if (state_q == RUN) begin
        acc_q   <= acc_d;
        carry_q <= is_add & alu_e_i;
        cnt_q   <= cnt_q + CW'(1);
        if (last_bit) begin
          res_o   <= acc_d;
          carry_o <= is_add & alu_e_i;
          owner_o <= idx_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_sched.sv
// Scoreboard bench for alu_serial_sched: WIDTH=8 main instance
// plus a WIDTH=4 instance, each paired with a 1-bit ALU model.
module tb_alu_serial_sched;

  typedef struct {
    logic        owner;
    logic [15:0] res;
    logic        carry;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]      req8 = '0;
  logic [1:0][7:0] opa8 = '0;
  logic [1:0][7:0] opb8 = '0;
  logic [1:0][1:0] opc8 = '0;
  logic [1:0]      gnt8;
  logic [7:0]      res8;
  logic            carry8, owner8, done8, busy8;
  logic            aa8, ab8, ac8, ad8, ae8;
  logic [1:0]      actr8;

  logic [1:0]      req4 = '0;
  logic [1:0][3:0] opa4 = '0;
  logic [1:0][3:0] opb4 = '0;
  logic [1:0][1:0] opc4 = '0;
  logic [1:0]      gnt4;
  logic [3:0]      res4;
  logic            carry4, owner4, done4, busy4;
  logic            aa4, ab4, ac4, ad4, ae4;
  logic [1:0]      actr4;

  alu_serial_sched #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_i(req8),
    .opn_a_i(opa8), .opn_b_i(opb8), .opn_ctl_i(opc8),
    .gnt_o(gnt8), .res_o(res8), .carry_o(carry8),
    .owner_o(owner8), .done_o(done8), .busy_o(busy8),
    .alu_a_o(aa8), .alu_b_o(ab8), .alu_c_o(ac8),
    .alu_ctr_o(actr8), .alu_d_i(ad8), .alu_e_i(ae8)
  );

  alu_serial_sched #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_i(req4),
    .opn_a_i(opa4), .opn_b_i(opb4), .opn_ctl_i(opc4),
    .gnt_o(gnt4), .res_o(res4), .carry_o(carry4),
    .owner_o(owner4), .done_o(done4), .busy_o(busy4),
    .alu_a_o(aa4), .alu_b_o(ab4), .alu_c_o(ac4),
    .alu_ctr_o(actr4), .alu_d_i(ad4), .alu_e_i(ae4)
  );

  // External 1-bit ALU: {carry, result}.
  function automatic logic [1:0] alu_bit(logic a, logic b,
                                         logic c, logic [1:0] s);
    case (s)
      2'b00:   return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
      2'b01:   return {1'b0, a & b};
      2'b10:   return {1'b0, ~(a | b)};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {ae8, ad8} = alu_bit(aa8, ab8, ac8, actr8);
  assign {ae4, ad4} = alu_bit(aa4, ab4, ac4, actr4);

  function automatic exp_t model(int w, logic owner, int a,
                                 int b, logic [1:0] s);
    exp_t e;
    int   mask;
    int   r;
    mask = (1 << w) - 1;
    e.owner = owner;
    e.carry = 1'b0;
    case (s)
      2'b00: begin
        r = a + b;
        e.carry = r[w];
      end
      2'b01:   r = a & b;
      2'b10:   r = ~(a | b);
      default: r = a ^ b;
    endcase
    e.res = 16'(r & mask);
    return e;
  endfunction

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  exp_t q8[$];
  exp_t q4[$];
  int   n_done8 = 0;
  int   bcnt = 0;
  int   busy_len = 0;

  // Scoreboard pop on every result pulse, main instance.
  always @(negedge clk) begin
    if (done8) begin
      exp_t e;
      n_done8++;
      if (q8.size() == 0) begin
        check("spurious_done8", 1, 0);
      end else begin
        e = q8.pop_front();
        check("res8", res8, e.res);
        check("carry8", carry8, e.carry);
        check("owner8", owner8, e.owner);
      end
      check("alu_quiet_done8", {aa8, ab8, ac8, actr8}, 0);
    end
  end

  // Scoreboard pop, WIDTH=4 instance.
  always @(negedge clk) begin
    if (done4) begin
      exp_t e;
      if (q4.size() == 0) begin
        check("spurious_done4", 1, 0);
      end else begin
        e = q4.pop_front();
        check("res4", res4, e.res);
        check("carry4", carry4, e.carry);
        check("owner4", owner4, e.owner);
      end
    end
  end

  // Length of each contiguous busy stretch.
  always @(negedge clk) begin
    if (busy8) begin
      bcnt = bcnt + 1;
    end else if (bcnt != 0) begin
      busy_len = bcnt;
      bcnt = 0;
    end
  end

  task automatic drive8(int who, logic [7:0] a, logic [7:0] b,
                        logic [1:0] s, bit push);
    opa8[who] = a;
    opb8[who] = b;
    opc8[who] = s;
    req8[who] = 1'b1;
    if (push) q8.push_back(model(8, who[0], a, b, s));
  endtask

  task automatic wait_gnt8(int who, output int gc);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt8 != 2'b00) break;
    end
    gc = cyc;
    check("gnt8", gnt8, 1 << who);
    req8[who] = 1'b0;
    @(negedge clk);
    check("gnt_pulse8", gnt8, 0);
  endtask

  task automatic wait_done8(output int dc);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) break;
    end
    dc = cyc;
    check("done_seen8", done8, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req8 = '0;
    req4 = '0;
    repeat (2) @(negedge clk);
    check("rst_out8", {gnt8, done8, busy8, res8, carry8, owner8,
                       aa8, ab8, ac8, actr8}, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc, dc, g1, nd;

    do_reset();

    drive8(0, 8'h5A, 8'h3C, 2'b00, 1);
    wait_gnt8(0, gc);
    wait_done8(dc);
    check("lat_done8", dc - gc, 8);
    repeat (3) @(negedge clk);
    check("res_hold8", res8, 8'h96);

    drive8(0, 8'hFF, 8'h01, 2'b00, 1);
    wait_gnt8(0, gc);
    wait_done8(dc);

    do_reset();
    drive8(0, 8'hF0, 8'h3C, 2'b01, 1);
    drive8(1, 8'h0F, 8'hF0, 2'b10, 1);
    wait_gnt8(0, gc);
    wait_done8(dc);
    wait_gnt8(1, g1);
    wait_done8(dc);

    drive8(0, 8'hA5, 8'hFF, 2'b11, 1);
    wait_gnt8(0, gc);
    drive8(1, 8'h10, 8'h20, 2'b00, 1);
    wait_done8(dc);
    wait_gnt8(1, g1);
    check("gnt_after_done8", g1 - dc, 2);
    check("busy_len8", busy_len, 9);
    wait_done8(dc);

    drive8(0, 8'h33, 8'h44, 2'b00, 0);
    wait_gnt8(0, gc);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out8", {gnt8, done8, busy8, res8, carry8,
                           owner8, aa8, ab8, ac8, actr8}, 0);
    rst_n = 1'b1;
    nd = n_done8;
    repeat (12) @(negedge clk);
    check("no_done_after_rst8", n_done8 - nd, 0);
    drive8(0, 8'h01, 8'h01, 2'b00, 1);
    wait_gnt8(0, gc);
    wait_done8(dc);

    opa4[0] = 4'hF;
    opb4[0] = 4'h1;
    opc4[0] = 2'b00;
    req4[0] = 1'b1;
    q4.push_back(model(4, 1'b0, 4'hF, 4'h1, 2'b00));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt4 != 2'b00) break;
    end
    gc = cyc;
    check("gnt4", gnt4, 1);
    req4[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4) break;
    end
    check("done_seen4", done4, 1);
    check("lat_done4", cyc - gc, 4);

    repeat (4) @(negedge clk);
    check("q8_empty", q8.size(), 0);
    check("q4_empty", q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
